// File: rtl/synth_pkg.sv
// Shared definitions for the tone synthesiser: default parameters, the
// envelope ceiling, the saturating adder used by the mixer, and the
// CLOCK_50 half-periods of the C..B note keys.
package synth_pkg;

  localparam int NUM_VOICES_DEF = 7;
  localparam int CNT_W_DEF      = 32;
  localparam int SAMPLE_W_DEF   = 32;
  localparam int ENV_W_DEF      = 8;
  localparam int AMP_SHIFT_DEF  = 19;
  localparam int ENV_STEP_DEF   = 1;
  localparam int ENV_DIV_DEF    = 1000;

  localparam int ENV_MAX = (1 << ENV_W_DEF) - 1;

  // Width of the scratch arithmetic inside sat_add; wide enough for any
  // realistic SAMPLE_W plus the growth from summing every voice.
  localparam int SAT_W = 64;

  typedef enum logic [2:0] {
    NOTE_C, NOTE_D, NOTE_E, NOTE_F, NOTE_G, NOTE_A, NOTE_B
  } note_e;

  // Half-periods in CLOCK_50 cycles for each key of the board.
  localparam logic [31:0] HP_C = 32'd96000;
  localparam logic [31:0] HP_D = 32'd86000;
  localparam logic [31:0] HP_E = 32'd76000;
  localparam logic [31:0] HP_F = 32'd71500;
  localparam logic [31:0] HP_G = 32'd64000;
  localparam logic [31:0] HP_A = 32'd57000;
  localparam logic [31:0] HP_B = 32'd51000;

  // Envelope ceiling for an arbitrary envelope width.
  function automatic int env_max(input int w);
    return (1 << w) - 1;
  endfunction

  // Half-period lookup for a note key.
  function automatic logic [31:0] note_half_period(input note_e n);
    case (n)
      NOTE_C:  return HP_C;
      NOTE_D:  return HP_D;
      NOTE_E:  return HP_E;
      NOTE_F:  return HP_F;
      NOTE_G:  return HP_G;
      NOTE_A:  return HP_A;
      default: return HP_B;
    endcase
  endfunction

  // Exact signed sum of a and b, clamped into the range of a w-bit signed
  // value. Callers pass operands already sign-extended to SAT_W.
  function automatic logic signed [SAT_W-1:0] sat_add(
    input logic signed [SAT_W-1:0] a,
    input logic signed [SAT_W-1:0] b,
    input int unsigned             w
  );
    logic signed [SAT_W-1:0] sum;
    logic signed [SAT_W-1:0] hi;
    logic signed [SAT_W-1:0] lo;
    sum = a + b;
    hi  = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo  = -(64'sd1 <<< (w - 1));
    if (sum > hi)      return hi;
    else if (sum < lo) return lo;
    else               return sum;
  endfunction

endpackage

// File: rtl/tone_voice.sv
// One square-wave voice: half-period phase counter, output polarity and a
// linear attack/release envelope. Produces its signed contribution to the
// mix and a flag that is set while the envelope is non-zero.
module tone_voice
  import synth_pkg::*;
#(
  parameter int CNT_W     = CNT_W_DEF,
  parameter int SAMPLE_W  = SAMPLE_W_DEF,
  parameter int ENV_W     = ENV_W_DEF,
  parameter int AMP_SHIFT = AMP_SHIFT_DEF,
  parameter int ENV_STEP  = ENV_STEP_DEF
) (
  input  logic                       clock,
  input  logic                       resetn,
  input  logic                       key_on,
  input  logic                       tick,
  input  logic [CNT_W-1:0]           half_period,
  output logic signed [SAMPLE_W-1:0] contrib,
  output logic                       active
);

  localparam logic [ENV_W:0] ENV_MAX_X = (ENV_W+1)'(env_max(ENV_W));
  localparam logic [ENV_W:0] STEP_X    = (ENV_W+1)'(ENV_STEP);

  logic [CNT_W-1:0]    cnt;
  logic                pol_neg;
  logic [ENV_W-1:0]    env;
  logic [ENV_W-1:0]    env_next;
  logic [ENV_W:0]      env_up;
  logic [SAMPLE_W-1:0] mag;
  logic                hp_zero;
  logic                running;
  logic                wrap;

  assign hp_zero = (half_period == '0);
  assign running = key_on || (env != '0);
  assign wrap    = (cnt >= half_period - CNT_W'(1));

  // Saturating envelope step, applied only on an envelope tick.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    env_next = env;
    env_up   = {1'b0, env} + STEP_X;
    if (tick) begin
      if (key_on)
        env_next = (env_up > ENV_MAX_X) ? ENV_MAX_X[ENV_W-1:0] : env_up[ENV_W-1:0];
      else
        env_next = ({1'b0, env} < STEP_X) ? '0 : env - STEP_X[ENV_W-1:0];
    end
  end

  // Phase counter, polarity and envelope registers.
  always_ff @(posedge clock or negedge resetn) begin
    // NOTE: non-blocking assignments so every register samples the values
    // from before this edge, independent of statement order.
    if (!resetn) begin
      cnt     <= '0;
      pol_neg <= 1'b0;
      env     <= '0;
      active  <= 1'b0;
    end else begin
      env    <= env_next;
      active <= (env_next != '0);
      if (hp_zero || !running) begin
        // Silent or idle: park at phase zero so the next note starts aligned.
        cnt     <= '0;
        pol_neg <= 1'b0;
      end else if (wrap) begin
        // >= rather than == so a half-period shortened mid-note wraps at once.
        cnt     <= '0;
        pol_neg <= ~pol_neg;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  // Signed contribution: envelope magnitude with the current polarity.
  always_comb begin
    mag     = SAMPLE_W'(env) << AMP_SHIFT;
    contrib = '0;
    if (!hp_zero)
      contrib = pol_neg ? -$signed(mag) : $signed(mag);
  end

endmodule

// File: rtl/tone_synth.sv
// N-voice square-wave synthesiser. Holds the free-running envelope tick
// divider, the saturating mixer and the registered stereo sample with its
// write strobe towards Audio_Controller.
module tone_synth
  import synth_pkg::*;
#(
  parameter int NUM_VOICES = NUM_VOICES_DEF,
  parameter int CNT_W      = CNT_W_DEF,
  parameter int SAMPLE_W   = SAMPLE_W_DEF,
  parameter int ENV_W      = ENV_W_DEF,
  parameter int AMP_SHIFT  = AMP_SHIFT_DEF,
  parameter int ENV_STEP   = ENV_STEP_DEF,
  parameter int ENV_DIV    = ENV_DIV_DEF
) (
  input  logic                        clock,
  input  logic                        resetn,
  input  logic [NUM_VOICES-1:0]       key_on,
  input  logic [NUM_VOICES*CNT_W-1:0] half_period,
  input  logic                        mute,
  input  logic                        audio_out_allowed,
  output logic [SAMPLE_W-1:0]         left_channel_audio_out,
  output logic [SAMPLE_W-1:0]         right_channel_audio_out,
  output logic                        write_audio_out,
  output logic [NUM_VOICES-1:0]       voice_active
);

  localparam int TICK_W = (ENV_DIV > 1) ? $clog2(ENV_DIV) : 1;
  localparam int MIX_W  = SAMPLE_W + ((NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 0);

  logic [TICK_W-1:0]          tick_cnt;
  logic                       tick;
  logic signed [SAMPLE_W-1:0] contrib [NUM_VOICES];
  logic signed [MIX_W-1:0]    acc;
  logic signed [SAMPLE_W-1:0] mix;

  assign tick = (tick_cnt == TICK_W'(ENV_DIV - 1));

  // Free-running envelope divider; key activity does not affect it.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn)   tick_cnt <= '0;
    else if (tick) tick_cnt <= '0;
    else           tick_cnt <= tick_cnt + TICK_W'(1);
  end

  for (genvar g = 0; g < NUM_VOICES; g++) begin : g_voice
    tone_voice #(
      .CNT_W     (CNT_W),
      .SAMPLE_W  (SAMPLE_W),
      .ENV_W     (ENV_W),
      .AMP_SHIFT (AMP_SHIFT),
      .ENV_STEP  (ENV_STEP)
    ) u_voice (
      .clock       (clock),
      .resetn      (resetn),
      .key_on      (key_on[g]),
      .tick        (tick),
      .half_period (half_period[g*CNT_W +: CNT_W]),
      .contrib     (contrib[g]),
      .active      (voice_active[g])
    );
  end

  // Exact sum of all but the last voice, then one saturating add folds in
  // the last voice and clamps to the sample range.
  always_comb begin
    acc = '0;
    for (int i = 0; i < NUM_VOICES - 1; i++)
      acc = acc + MIX_W'(contrib[i]);
    mix = SAMPLE_W'(sat_add(SAT_W'(acc), SAT_W'(contrib[NUM_VOICES-1]), SAMPLE_W));
    if (mute) mix = '0;
  end

  // Output register: same sample on both channels, strobe follows the FIFO flag.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      left_channel_audio_out  <= '0;
      right_channel_audio_out <= '0;
      write_audio_out         <= 1'b0;
    end else begin
      left_channel_audio_out  <= mix;
      right_channel_audio_out <= mix;
      write_audio_out         <= audio_out_allowed;
    end
  end

endmodule

// File: tb/tb_tone_synth.sv
// Bench for tone_synth: two instances (16-bit and 9-bit samples) share one
// stimulus; a behavioural model predicts every output each cycle, and
// directed phases pin attack/release levels, half-period timing,
// saturation, silence, mute and the write strobe with literal values.
module tb_tone_synth;

  localparam int NV = 2;
  localparam int CW = 8;
  localparam int EW = 8;
  localparam int ES = 64;
  localparam int ED = 4;
  localparam int AS = 0;
  localparam int EMAX = 255;

  logic               clock = 1'b0;
  logic               resetn = 1'b0;
  logic [NV-1:0]      key_on = '0;
  logic [NV*CW-1:0]   half_period = '0;
  logic               mute = 1'b0;
  logic               allowed = 1'b0;
  logic signed [15:0] l16, r16;
  logic signed [8:0]  l9, r9;
  logic               w16, w9;
  logic [NV-1:0]      a16, a9;

  int n_cmp = 0;
  int n_err = 0;
  bit cmp_en = 1'b0;

  always #5 clock = ~clock;

  tone_synth #(.NUM_VOICES(NV), .CNT_W(CW), .SAMPLE_W(16), .ENV_W(EW),
               .AMP_SHIFT(AS), .ENV_STEP(ES), .ENV_DIV(ED)) dut16 (
    .clock(clock), .resetn(resetn), .key_on(key_on), .half_period(half_period),
    .mute(mute), .audio_out_allowed(allowed),
    .left_channel_audio_out(l16), .right_channel_audio_out(r16),
    .write_audio_out(w16), .voice_active(a16));

  tone_synth #(.NUM_VOICES(NV), .CNT_W(CW), .SAMPLE_W(9), .ENV_W(EW),
               .AMP_SHIFT(AS), .ENV_STEP(ES), .ENV_DIV(ED)) dut9 (
    .clock(clock), .resetn(resetn), .key_on(key_on), .half_period(half_period),
    .mute(mute), .audio_out_allowed(allowed),
    .left_channel_audio_out(l9), .right_channel_audio_out(r9),
    .write_audio_out(w9), .voice_active(a9));

  task automatic check(input string name, input logic signed [31:0] act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int m_env [NV];
  int m_pos [NV];   // clocks already spent in the current half-cycle
  int m_sgn [NV];   // +1 / -1
  int m_n = 0;      // clocks since reset release
  int exp16 = 0, exp9 = 0, exp_wr = 0, exp_act = 0;

  function automatic int hp_of(input int v);
    return int'(half_period[v*CW +: CW]);
  endfunction

  function automatic int clampw(input int s, input int w);
    int hi, lo;
    hi = (1 << (w - 1)) - 1;
    lo = -(1 << (w - 1));
    return (s > hi) ? hi : (s < lo) ? lo : s;
  endfunction

  task automatic model_reset();
    for (int v = 0; v < NV; v++) begin
      m_env[v] = 0; m_pos[v] = 0; m_sgn[v] = 1;
    end
    m_n = 0; exp16 = 0; exp9 = 0; exp_wr = 0; exp_act = 0;
  endtask

  task automatic model_step();
    int  sum, hp;
    bit  tick;
    sum = 0;
    for (int v = 0; v < NV; v++)
      if (hp_of(v) != 0) sum += m_sgn[v] * m_env[v];
    exp16  = mute ? 0 : clampw(sum, 16);
    exp9   = mute ? 0 : clampw(sum, 9);
    exp_wr = int'(allowed);
    tick   = ((m_n % ED) == ED - 1);
    m_n++;
    exp_act = 0;
    for (int v = 0; v < NV; v++) begin
      hp = hp_of(v);
      if (hp == 0 || (!key_on[v] && m_env[v] == 0)) begin
        m_pos[v] = 0; m_sgn[v] = 1;
      end else if (m_pos[v] + 1 >= hp) begin
        m_pos[v] = 0; m_sgn[v] = -m_sgn[v];
      end else begin
        m_pos[v]++;
      end
      if (tick) begin
        if (key_on[v]) m_env[v] = (m_env[v] + ES > EMAX) ? EMAX : m_env[v] + ES;
        else           m_env[v] = (m_env[v] - ES < 0) ? 0 : m_env[v] - ES;
      end
      if (m_env[v] != 0) exp_act |= (1 << v);
    end
  endtask

  always @(posedge clock or negedge resetn) begin
    if (!resetn) model_reset();
    else         model_step();
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clock) begin
    if (cmp_en) begin
      check("left16",   l16, exp16);
      check("right16",  r16, exp16);
      check("left9",    l9,  exp9);
      check("right9",   r9,  exp9);
      check("write16",  w16, exp_wr);
      check("write9",   w9,  exp_wr);
      check("active16", a16, exp_act);
      check("active9",  a9,  exp_act);
    end
  end

  // ---------------- directed helpers ----------------
  int rec [$];
  int rv [$];
  int rl [$];

  task automatic record16(input int n);
    rec.delete();
    repeat (n) begin
      @(negedge clock);
      rec.push_back(int'(l16));
    end
  endtask

  task automatic make_runs(input bit by_sign);
    int key;
    rv.delete(); rl.delete();
    foreach (rec[i]) begin
      key = by_sign ? ((rec[i] < 0) ? -1 : 1) : ((rec[i] < 0) ? -rec[i] : rec[i]);
      if (i == 0 || key != rv[rv.size()-1]) begin
        rv.push_back(key); rl.push_back(1);
      end else begin
        rl[rl.size()-1]++;
      end
    end
  endtask

  task automatic set_hp(input int v, input int hp);
    half_period[v*CW +: CW] = CW'(hp);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int levels_up [5];
    int levels_dn [5];
    int pat [4];
    int wexp [5];
    int nz, mx9, mn9, mx16, mn16;
    bit found;
    levels_up = '{0, 64, 128, 192, 255};
    levels_dn = '{255, 191, 127, 63, 0};
    pat  = '{1, 0, 1, 1};
    wexp = '{0, 1, 0, 1, 1};

    @(posedge clock);
    cmp_en = 1'b1;

    // Reset held: keys toggling and FIFO space must not disturb the outputs.
    allowed = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      check("reset_out", l16, 0);
      check("reset_active", a16, 0);
      check("reset_write", w16, 0);
      #1 key_on = NV'($urandom);
      set_hp(0, 10);
    end
    #1 key_on = '0; resetn = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      check("idle_out", l16, 0);
    end

    // Attack.
    #1 set_hp(0, 10); key_on = 2'b01;
    record16(24);
    make_runs(1'b0);
    check("attack_levels", rv.size(), 5);
    if (rv.size() == 5) begin
      for (int i = 0; i < 5; i++) check("attack_level", rv[i], levels_up[i]);
      for (int i = 1; i < 4; i++) check("attack_len", rl[i], 4);
    end

    // Frequency at full envelope.
    record16(64);
    nz = 0;
    foreach (rec[i]) if (rec[i] != 255 && rec[i] != -255) nz++;
    check("freq_mag", nz, 0);
    make_runs(1'b1);
    check("freq_runs", int'(rv.size() >= 4), 1);
    for (int i = 1; i < rv.size() - 1; i++) check("freq_half10", rl[i], 10);

    // Shorten the half-period while the counter sits at 7.
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clock);
      if (m_pos[0] == 7) found = 1'b1;
    end
    check("wait_cnt7", int'(found), 1);
    #1 set_hp(0, 3);
    record16(30);
    make_runs(1'b1);
    check("hp3_runs", int'(rv.size() >= 4), 1);
    for (int i = 1; i < rv.size() - 1; i++) check("hp3_half", rl[i], 3);

    // Release.
    #1 set_hp(0, 10); key_on = '0;
    record16(24);
    make_runs(1'b0);
    check("release_levels", rv.size(), 5);
    if (rv.size() == 5) begin
      for (int i = 0; i < 5; i++) check("release_level", rv[i], levels_dn[i]);
      for (int i = 1; i < 4; i++) check("release_len", rl[i], 4);
    end
    check("release_active", a16, 0);
    check("release_out", l16, 0);

    // Saturation: two aligned voices at full envelope.
    #1 set_hp(0, 20); set_hp(1, 20); key_on = 2'b11;
    repeat (24) @(negedge clock);
    mx9 = -1000; mn9 = 1000; mx16 = -1000; mn16 = 1000;
    repeat (80) begin
      @(negedge clock);
      if (l9 > mx9) mx9 = l9;
      if (l9 < mn9) mn9 = l9;
      if (l16 > mx16) mx16 = l16;
      if (l16 < mn16) mn16 = l16;
    end
    check("sat_pos9", mx9, 255);
    check("sat_neg9", mn9, -256);
    check("sum_pos16", mx16, 510);
    check("sum_neg16", mn16, -510);
    #1 key_on = '0;
    repeat (24) @(negedge clock);

    // Zero half-period: silent while the envelope still rises.
    #1 set_hp(0, 0); key_on = 2'b01;
    nz = 0;
    repeat (24) begin
      @(negedge clock);
      if (l16 != 0 || l9 != 0) nz++;
    end
    check("zero_hp_silent", nz, 0);
    check("zero_hp_active", a16, 1);

    // Mute with an active voice, then resume at full envelope.
    #1 set_hp(0, 10); mute = 1'b1;
    nz = 0;
    repeat (20) begin
      @(negedge clock);
      if (l16 != 0) nz++;
    end
    check("mute_silent", nz, 0);
    #1 mute = 1'b0;
    @(negedge clock);
    check("unmute_mag", (l16 < 0) ? -l16 : l16, 255);

    // Write strobe lags audio_out_allowed by one clock.
    #1 allowed = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      check("write_lag", w16, wexp[i]);
      if (i < 4) #1 allowed = pat[i][0];
    end

    // Randomized traffic, with one asynchronous reset in the middle.
    for (int i = 0; i < 3000; i++) begin
      @(negedge clock);
      #1;
      if ($urandom_range(15) == 0) key_on = NV'($urandom);
      if ($urandom_range(63) == 0) set_hp($urandom_range(NV - 1), $urandom_range(15));
      if ($urandom_range(99) == 0) mute = ~mute;
      allowed = 1'($urandom);
      if (i == 1500) resetn = 1'b0;
      if (i == 1503) resetn = 1'b1;
    end

    repeat (2) @(negedge clock);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/tone_synth.md
Name: tone_synth

Overview:
- N-voice square-wave tone synthesiser. Replaces the hard-coded per-note counters in the top level.
- Each voice has a runtime-programmable half-period and a linear attack/release envelope, which removes key-on/off clicks.
- Voices are summed with saturation into a registered stereo sample, handed to Audio_Controller with a write strobe.
- Keys come from the SW switches or the processor-driven highlight bus.

Parameters:
- NUM_VOICES, 7, number of voices (C..B).
- CNT_W, 32, width of each half-period counter and of each half_period field.
- SAMPLE_W, 32, signed width of the audio sample.
- ENV_W, 8, envelope width; ENV_MAX = 2^ENV_W-1.
- AMP_SHIFT, 19, voice amplitude = env << AMP_SHIFT (255<<19 = 133693440).
- ENV_STEP, 1, envelope increment/decrement per envelope tick.
- ENV_DIV, 1000, clocks per envelope tick.

Ports:
- clock  in  1  system clock (CLOCK_50 domain).
- resetn  in  1  asynchronous active-low reset.
- key_on  in  NUM_VOICES  per-voice gate, bit i = voice i.
- half_period  in  NUM_VOICES*CNT_W  packed unsigned half-periods in clocks; field i = bits [i*CNT_W +: CNT_W].
- mute  in  1  forces the mixed sample to 0; envelopes keep running.
- audio_out_allowed  in  1  from Audio_Controller; FIFO has space.
- left_channel_audio_out  out  SAMPLE_W  registered mixed sample.
- right_channel_audio_out  out  SAMPLE_W  identical to left.
- write_audio_out  out  1  one-cycle-registered write strobe.
- voice_active  out  NUM_VOICES  bit i = (env_i != 0).

Behaviour:
- Reset (async, resetn=0): all counters 0, all polarities positive, all env 0, tick counter 0, audio outputs 0, write_audio_out 0, voice_active 0.
- Envelope tick: the tick counter runs 0..ENV_DIV-1. tick=1 in the cycle it equals ENV_DIV-1, then it wraps to 0. It is free-running and ignores key_on.
- Envelope, per voice, on tick:
  - key_on=1: env <= min(env+ENV_STEP, ENV_MAX).
  - key_on=0: env <= max(env-ENV_STEP, 0).
  - Saturating; no wrap-around.
- Phase, per voice, while key_on=1 or env!=0:
  - cnt increments each clock.
  - When cnt >= half_period-1: cnt <= 0 and polarity toggles.
  - The >= compare means a half_period reduced mid-note wraps on the next cycle.
  - Each half-cycle lasts exactly half_period clocks.
- half_period = 0: the voice is held silent. cnt=0, polarity positive, voice contribution 0; the envelope still runs.
- Voice idle (key_on=0 and env=0): cnt <= 0 and polarity <= positive, so the next note starts phase-aligned.
- Voice contribution: +(env<<AMP_SHIFT) if polarity is positive, else -(env<<AMP_SHIFT). Zero-extend the magnitude to SAMPLE_W before the shift.
- Mix: signed sum of all contributions in SAMPLE_W+clog2(NUM_VOICES) bits, saturated to [-2^(SAMPLE_W-1), 2^(SAMPLE_W-1)-1]. If mute=1, the mix is 0.
- Output register, every clock: left = right = mix; write_audio_out <= audio_out_allowed. Latency is one clock from a counter/env change to the outputs.
- Simultaneous events:
  - Key release in the same cycle as a tick: the decrement applies this tick.
  - Key re-press during release: rises from the current env; no restart.
- voice_active: registered, updated with env.

Decomposition:
- Package synth_pkg:
  - default parameters;
  - ENV_MAX;
  - function sat_add for the saturating signed sum;
  - C..B half-period constants for CLOCK_50 (96000, 86000, 76000, 71500, 64000, 57000, 51000).
- Sub-module tone_voice: one instance per voice in a generate loop. It holds cnt, polarity and env, and outputs its signed contribution and active flag.
- tone_synth holds the tick counter, the mixer/saturation and the output register.

Test Plan (ENV_DIV=4, ENV_STEP=64, ENV_W=8, AMP_SHIFT=0, SAMPLE_W=16, NUM_VOICES=2 unless stated):
- Reset: hold resetn=0, pulse clock, toggle key_on -> all outputs 0, voice_active=00; deassert -> outputs remain 0 until key_on.
- Attack/release: key_on=01, half_period0=10 -> env0 steps 64,128,192,255 every 4 clocks and holds at 255. Release -> 191,127,63,0. voice_active[0] clears on the env=0 update, and cnt0/polarity reset.
- Frequency: key_on=01, half_period0=10, env settled at 255 -> output alternates +255/-255 every 10 clocks exactly. Change half_period0 to 3 while cnt0=7 -> toggle on the next cycle, then every 3 clocks.
- Saturation: NUM_VOICES=2, SAMPLE_W=9, AMP_SHIFT=0, both voices at env 255 with positive polarity -> output 255. Both negative -> -256 (clamped from -510).
- Zero half_period and mute: half_period0=0 with key_on=01 -> output 0 while env0 rises to 255. mute=1 with an active voice -> output 0; mute=0 -> the waveform resumes with no envelope reset.
- Handshake: audio_out_allowed pattern 1,0,1,1 -> write_audio_out 0,1,0,1,1 (one-cycle lag); left == right on every cycle.
